// File: rtl/regfile_dump_unit.sv
// Walks the register file after end-of-program and streams each register over
// valid/ready, keeping a running XOR checksum of the accepted words.
module regfile_dump_unit #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              _clock,
    input  logic              _reset,
    input  logic              halt_i,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic [DATA_W-1:0] checksum,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] dindex_q, dindex_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            raddr_q  <= '0;
            dindex_q <= '0;
            data_q   <= '0;
            csum_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            raddr_q  <= raddr_d;
            dindex_q <= dindex_d;
            data_q   <= data_d;
            csum_q   <= csum_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; flag outputs are decoded from the next state so they stay registered.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        raddr_d  = raddr_q;
        dindex_d = dindex_q;
        data_d   = data_q;
        csum_d   = csum_q;

        case (state_q)
            IDLE: begin
                if (halt_i) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    raddr_d = '0;
                end
            end
            FETCH: begin
                data_d   = rf_rdata;
                dindex_d = idx_q;
                state_d  = SEND;
            end
            SEND: begin
                if (dump_ready) begin
                    csum_d = csum_q ^ data_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        raddr_d = idx_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == SEND);
        busy_d  = (state_d == FETCH) || (state_d == SEND);
        done_d  = (state_d == DONE);
    end

    assign rf_raddr   = raddr_q;
    assign dump_valid = valid_q;
    assign dump_index = dindex_q;
    assign dump_data  = data_q;
    assign checksum   = csum_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit: full-size instance plus an 8-register instance.
module tb_regfile_dump_unit;

    logic        clk;
    logic        rst;
    logic        halt;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        valid;
    logic        ready;
    logic [4:0]  dindex;
    logic [31:0] ddata;
    logic [31:0] csum;
    logic        busy;
    logic        done;

    logic        halt2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        valid2;
    logic        ready2;
    logic [4:0]  dindex2;
    logic [31:0] ddata2;
    logic [31:0] csum2;
    logic        busy2;
    logic        done2;

    logic [31:0] rf [32];

    int checks;
    int errors;

    assign rdata  = rf[raddr];
    assign rdata2 = rf[raddr2];

    regfile_dump_unit #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        ._clock(clk), ._reset(rst), .halt_i(halt),
        .rf_raddr(raddr), .rf_rdata(rdata),
        .dump_valid(valid), .dump_ready(ready),
        .dump_index(dindex), .dump_data(ddata),
        .checksum(csum), .busy(busy), .done(done)
    );

    regfile_dump_unit #(.NUM_REGS(8), .ADDR_W(5), .DATA_W(32)) dut8 (
        ._clock(clk), ._reset(rst), .halt_i(halt2),
        .rf_raddr(raddr2), .rf_rdata(rdata2),
        .dump_valid(valid2), .dump_ready(ready2),
        .dump_index(dindex2), .dump_data(ddata2),
        .checksum(csum2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_busy"},  32'(busy),  32'd0);
        check({tag, "_done"},  32'(done),  32'd0);
        check({tag, "_index"}, 32'(dindex), 32'd0);
        check({tag, "_data"},  ddata, 32'd0);
        check({tag, "_csum"},  csum, 32'd0);
        check({tag, "_raddr"}, 32'(raddr), 32'd0);
    endtask

    // Run the 32-entry instance until done, checking every accepted word is the next index in order.
    task automatic drain(input int start, input int budget, output int nx, output int cyc);
        nx  = 0;
        cyc = 0;
        while (!done && cyc < budget) begin
            if (valid && ready) begin
                check("xfer_index", 32'(dindex), 32'(start + nx));
                check("xfer_data", ddata, rf[(start + nx) % 32]);
                nx++;
            end
            tick();
            cyc++;
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] xor_range(input int n);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < n; i++) acc = acc ^ rf[i];
        return acc;
    endfunction

    initial begin
        int nx;
        int cyc;
        int seen;
        logic [31:0] cs_before;
        logic [31:0] cs_final;
        logic [31:0] exp_cs;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        halt   = 1'b0;
        ready  = 1'b1;
        halt2  = 1'b0;
        ready2 = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);

        // Reset then idle.
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_reset_outputs("idle");

        // Full dump, ready held high, single-cycle halt pulse.
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("fetch_busy", 32'(busy), 32'd1);
        check("fetch_valid", 32'(valid), 32'd0);
        check("fetch_raddr", 32'(raddr), 32'd0);
        drain(0, 200, nx, cyc);
        check("full_count", 32'(nx), 32'd32);
        check("full_cycles", 32'(cyc), 32'd64);
        exp_cs = '0;
        for (int i = 0; i < 32; i++) exp_cs = exp_cs ^ 32'(i * 3);
        check("full_csum", csum, exp_cs);
        check("full_busy", 32'(busy), 32'd0);
        check("full_valid", 32'(valid), 32'd0);

        // Backpressure on index 4.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rf[4] = 32'hDEADBEEF;
        ready = 1'b1;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        cyc = 0;
        while (!(valid && dindex == 5'd4) && cyc < 50) begin
            tick();
            cyc++;
        end
        check("bp_reach4", 32'(dindex), 32'd4);
        ready = 1'b0;
        cs_before = 32'd0 ^ 32'd3 ^ 32'd6 ^ 32'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(valid), 32'd1);
            check("bp_index", 32'(dindex), 32'd4);
            check("bp_data", ddata, 32'hDEADBEEF);
            check("bp_csum_hold", csum, cs_before);
        end
        ready = 1'b1;
        tick();
        check("bp_csum_upd", csum, cs_before ^ 32'hDEADBEEF);
        check("bp_after_valid", 32'(valid), 32'd0);
        check("bp_after_busy", 32'(busy), 32'd1);
        tick();
        check("bp_next_index", 32'(dindex), 32'd5);
        drain(5, 200, nx, cyc);
        check("bp_rest_count", 32'(nx), 32'd27);
        check("bp_final_csum", csum, xor_range(32));

        // halt held high through the dump and after done.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        halt = 1'b1;
        tick();
        drain(0, 200, nx, cyc);
        check("hold_count", 32'(nx), 32'd32);
        cs_final = xor_range(32);
        check("hold_csum", csum, cs_final);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid || busy || !done) seen++;
        end
        halt = 1'b0;
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid || busy || !done) seen++;
        end
        check("hold_no_redump", 32'(seen), 32'd0);
        check("hold_done", 32'(done), 32'd1);
        check("hold_csum_frozen", csum, cs_final);

        // Reset mid-dump, then restart.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        cyc = 0;
        while (!(valid && dindex == 5'd10) && cyc < 100) begin
            tick();
            cyc++;
        end
        check("mid_reach10", 32'(dindex), 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_raddr", 32'(raddr), 32'd0);
        tick();
        check("restart_valid", 32'(valid), 32'd1);
        check("restart_index", 32'(dindex), 32'd0);
        check("restart_csum", csum, 32'd0);
        drain(0, 200, nx, cyc);
        check("restart_count", 32'(nx), 32'd32);
        check("restart_final_csum", csum, xor_range(32));

        // Eight-register instance with random backpressure.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        halt2 = 1'b1;
        tick();
        halt2 = 1'b0;
        nx = 0;
        cyc = 0;
        while (!done2 && cyc < 500) begin
            ready2 = 1'($urandom_range(0, 1));
            if (valid2 && ready2) begin
                check("r8_index", 32'(dindex2), 32'(nx));
                check("r8_data", ddata2, rf[nx % 32]);
                nx++;
            end
            tick();
            cyc++;
        end
        ready2 = 1'b1;
        check("r8_done", 32'(done2), 32'd1);
        check("r8_count", 32'(nx), 32'd8);
        check("r8_csum", csum2, xor_range(8));
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid2 || busy2) seen++;
        end
        check("r8_quiet", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_dump_unit.md
Name: regfile_dump_unit

Overview:
Downstream consumer of the single-cycle datapath. When the datapath signals end-of-program, this block walks the register file through a dedicated read port and streams each register over a valid/ready interface. It also keeps a running XOR checksum, so benches and host logic can check final architectural state without reaching into hierarchy.

Parameters:
NUM_REGS, 32, number of registers dumped (indices 0..NUM_REGS-1).
ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
DATA_W, 32, register data width.

Ports:
_clock  input  1  system clock; all state updates on rising edge.
_reset  input  1  synchronous, active-high reset.
halt_i  input  1  end-of-program indication from datapath, level or pulse; sampled every cycle.
rf_raddr  output  ADDR_W  read address to register-file dump port.
rf_rdata  input  DATA_W  combinational read data for rf_raddr.
dump_valid  output  1  dump_index/dump_data valid.
dump_ready  input  1  consumer accepts the current word.
dump_index  output  ADDR_W  register index of current word.
dump_data  output  DATA_W  register contents of current word.
checksum  output  DATA_W  XOR of all words accepted so far in this dump.
busy  output  1  dump in progress (FETCH or SEND).
done  output  1  all NUM_REGS words accepted; sticky until reset.

Behaviour:
- Reset (_reset=1 at a rising edge): state=IDLE, rf_raddr=0, dump_valid=0, dump_index=0, dump_data=0, checksum=0, busy=0, done=0. Reset mid-dump aborts immediately; no partial state survives.
- States: IDLE, FETCH, SEND, DONE.
- IDLE: if halt_i=1 at the edge, go to FETCH and set index=0. Otherwise stay.
- FETCH (1 cycle): drive rf_raddr=index. At the edge:
  - latch dump_data<=rf_rdata and dump_index<=index;
  - go to SEND.
- SEND: dump_valid=1.
  - dump_data and dump_index hold stable while dump_ready=0. Valid is never withdrawn once asserted.
  - On an edge with dump_ready=1 (transfer):
    - checksum<=checksum^dump_data;
    - if index==NUM_REGS-1, go to DONE; otherwise index<=index+1 and go to FETCH.
- DONE: dump_valid=0, done=1, busy=0, checksum frozen. halt_i is ignored. Only reset leaves DONE.
- busy=1 exactly in FETCH and SEND. dump_valid=1 exactly in SEND.
- Latency:
  - halt_i sampled at edge k gives first dump_valid=1 in the cycle after edge k+1.
  - Each word takes at least 2 cycles (FETCH+SEND).
  - A full dump with ready held high takes 2*NUM_REGS cycles from the first FETCH to DONE.
- halt_i toggling or deasserting during FETCH/SEND has no effect; the dump always completes.
- Index counter width is ADDR_W. Termination compares against NUM_REGS-1 and never relies on wrap-around, so NUM_REGS < 2**ADDR_W works.
- Register 0 is dumped like any other, with whatever value the port returns.
- rf_raddr holds its last value outside FETCH. The register file read port is read-only, so this has no side effects.

Test Plan:
- Reset then idle: _reset=1 for 2 cycles, halt_i=0 for 10 cycles -> all outputs 0, state IDLE, rf_raddr=0.
- Full dump with ready held high: load regfile with reg[i]=i*3, pulse halt_i 1 cycle -> 32 transfers, index 0..31 with data 0,3,...,93 in order; done=1 exactly 64 cycles after the first FETCH; checksum = XOR of i*3 for i=0..31.
- Backpressure: dump_ready=0 for 5 cycles while index=4 (reg[4]=32'hDEADBEEF) -> dump_valid stays 1 and dump_index=4, dump_data=32'hDEADBEEF stay stable; the word transfers exactly once after ready rises; checksum updates only on that cycle.
- halt_i held high throughout plus a second halt pulse after done -> exactly one dump of 32 words; done stays 1; checksum unchanged after DONE.
- Reset mid-dump: assert _reset when dump_index=10, then pulse halt_i -> outputs return to reset values; the new dump restarts at index 0 with checksum starting from 0.
- Reduced size: NUM_REGS=8, ADDR_W=5, ready random 50% -> exactly 8 words (indices 0..7) in order, no duplicates or drops, done=1 afterwards, checksum = XOR of reg[0..7].
